// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4 -- 4x4 matrix keypad scanner.
// Drives one active-low column at a time and samples the rows through a
// two-flop synchronizer. Each complete 16-key snapshot is debounced.
// Single-key presses are reported through a 1-deep valid/ready register.
// An event that arrives while the register is still full is dropped and
// sets a sticky overflow flag.
// Optional feature: define KEYPAD_RELEASE_EN to also report single-key
// releases (o_REL=1). Without it, o_REL is tied to 0.

module keypad_scan_4x4 #(
   parameter int SCAN_DIV       = 4096,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       i_CLK,
   input  logic       i_RST_N,
   output logic [3:0] o_COL,
   input  logic [3:0] i_ROW,
   output logic       o_VALID,
   input  logic       i_READY,
   output logic [3:0] o_KEY,
   output logic       o_REL,
   output logic       o_OVF,
   output logic       o_ANY
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEBOUNCE_SCANS);

   logic [3:0]       row_meta_reg;
   logic [3:0]       row_sync_reg;
   logic [3:0]       pressed;
   logic [DIV_W-1:0] dwell_reg;
   logic [1:0]       col_reg;
   logic             sample;
   logic             scan_end;
   logic [15:0]      raw_reg;
   logic [15:0]      raw_next;
   logic [15:0]      prev_reg;
   logic [15:0]      stable_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             update;
   logic             press_evt;
   logic             release_evt;
   logic             event_fire;
   logic [3:0]       event_key;
   logic             handshake;
   logic             valid_reg;
   logic             valid_next;
   logic [3:0]       key_reg;
   logic [3:0]       key_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             any_reg;
`ifdef KEYPAD_RELEASE_EN
   logic             rel_reg;
   logic             rel_next;
`endif

   // Index of the (single) set bit of a snapshot.
   function automatic logic [3:0] key_index(input logic [15:0] bits);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (bits[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Two-flop synchronizer for the asynchronous rows; idles as "not pressed".
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         row_meta_reg <= 4'hF;
         row_sync_reg <= 4'hF;
      end else begin
         row_meta_reg <= i_ROW;
         row_sync_reg <= row_meta_reg;
      end
   end

   assign pressed  = ~row_sync_reg;
   assign sample   = (dwell_reg == DWELL_LAST);
   assign scan_end = sample && (col_reg == 2'd3);

   // Column dwell timer and column pointer; both wrap silently.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         dwell_reg <= '0;
         col_reg   <= 2'd0;
      end else if (sample) begin
         dwell_reg <= '0;
         col_reg   <= col_reg + 2'd1;
      end else begin
         dwell_reg <= dwell_reg + DIV_W'(1);
      end
   end

   assign o_COL = ~(4'b0001 << col_reg);

   // Each column's row nibble is replaced on its own sample cycle. At scan end
   // raw_next therefore already holds the complete snapshot, col 3 included.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_col
         assign raw_next[gi*4 +: 4] = (sample && (col_reg == 2'(gi))) ?
                                      pressed : raw_reg[gi*4 +: 4];
      end
   endgenerate

   // Run length of identical consecutive scans, saturating at the threshold.
   always_comb begin
      cnt_next = cnt_reg;
      if (raw_next == prev_reg) begin
         if (cnt_reg != CNT_FULL) cnt_next = cnt_reg + CNT_W'(1);
      end else begin
         cnt_next = CNT_W'(1);
      end
   end

   assign update = scan_end && (cnt_next == CNT_FULL) && (raw_next != stable_reg);

   // Snapshot registers: raw accumulator, previous scan, debounced state.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         raw_reg    <= '0;
         prev_reg   <= '0;
         stable_reg <= '0;
         cnt_reg    <= '0;
         any_reg    <= 1'b0;
      end else begin
         raw_reg <= raw_next;
         if (scan_end) begin
            prev_reg <= raw_next;
            cnt_reg  <= cnt_next;
         end
         if (update) begin
            stable_reg <= raw_next;
            any_reg    <= |raw_next;
         end
      end
   end

   // A press needs the matrix fully released beforehand; chords and rollover are silent.
   assign press_evt = (stable_reg == '0) && $onehot(raw_next);
`ifdef KEYPAD_RELEASE_EN
   assign release_evt = $onehot(stable_reg) && (raw_next == '0);
`else
   assign release_evt = 1'b0;
`endif
   assign event_fire = update && (press_evt || release_evt);
   assign event_key  = release_evt ? key_index(stable_reg) : key_index(raw_next);
   assign handshake  = valid_reg && i_READY;

   // 1-deep output slot: load when free or being drained, otherwise drop and flag.
   always_comb begin
      valid_next = valid_reg;
      key_next   = key_reg;
      ovf_next   = ovf_reg;
`ifdef KEYPAD_RELEASE_EN
      rel_next   = rel_reg;
`endif
      if (handshake) begin
         valid_next = 1'b0;
         ovf_next   = 1'b0;
      end
      if (event_fire) begin
         if (!valid_reg || i_READY) begin
            valid_next = 1'b1;
            key_next   = event_key;
`ifdef KEYPAD_RELEASE_EN
            rel_next   = release_evt;
`endif
         end else begin
            ovf_next = 1'b1;
         end
      end
   end

   // Output register state.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         valid_reg <= 1'b0;
         key_reg   <= '0;
         ovf_reg   <= 1'b0;
`ifdef KEYPAD_RELEASE_EN
         rel_reg   <= 1'b0;
`endif
      end else begin
         valid_reg <= valid_next;
         key_reg   <= key_next;
         ovf_reg   <= ovf_next;
`ifdef KEYPAD_RELEASE_EN
         rel_reg   <= rel_next;
`endif
      end
   end

   assign o_VALID = valid_reg;
   assign o_KEY   = key_reg;
   assign o_OVF   = ovf_reg;
   assign o_ANY   = any_reg;
`ifdef KEYPAD_RELEASE_EN
   assign o_REL   = rel_reg;
`else
   assign o_REL   = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Testbench for keypad_scan_4x4 (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// A keypad matrix model turns a 16-bit "keys held" vector into row levels.
// A behavioural reference predicts every output on every cycle.
// Directed scenarios carry literal expectations; a randomized phase follows.

module tb_keypad_scan_4x4;

   localparam int SD = 4;
   localparam int DB = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  row_drv;
   logic        valid;
   logic        ready = 1'b0;
   logic [3:0]  key;
   logic        rel;
   logic        ovf;
   logic        any;
   logic [15:0] keys  = 16'h0000;

   int checks = 0;
   int passed = 0;

   // reference model state
   int          m_edges;
   logic [3:0]  m_rowq[$];
   logic [15:0] m_scan;
   logic [15:0] m_stable;
   logic [15:0] m_hist[$];
   logic        m_valid;
   logic [3:0]  m_key;
   logic        m_rel;
   logic        m_ovf;

   // accepted-event log (observed handshakes)
   int          acc_cnt = 0;
   logic [3:0]  acc_key[$];
   logic        acc_rel[$];

   always #5 clk = ~clk;

   keypad_scan_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .i_CLK   (clk),
      .i_RST_N (rst_n),
      .o_COL   (col),
      .i_ROW   (row),
      .o_VALID (valid),
      .i_READY (ready),
      .o_KEY   (key),
      .o_REL   (rel),
      .o_OVF   (ovf),
      .o_ANY   (any)
   );

   // Matrix: a held key pulls its row low while its column is driven low.
   always_comb begin
      row_drv = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4 + r] && !col[c]) row_drv[r] = 1'b0;
   end
   assign row = row_drv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [3:0] bit_pos(input logic [15:0] v);
      logic [3:0] p;
      p = 4'd0;
      for (int i = 0; i < 16; i++) if (v[i]) p = 4'(i);
      return p;
   endfunction

   task automatic model_reset();
      m_edges  = 0;
      m_rowq   = {4'hF, 4'hF};
      m_scan   = 16'h0;
      m_stable = 16'h0;
      m_hist   = {};
      m_valid  = 1'b0;
      m_key    = 4'h0;
      m_rel    = 1'b0;
      m_ovf    = 1'b0;
   endtask

   // One clock edge of the reference: row seen now is what was on the pins two edges ago.
   task automatic model_step(input logic [3:0] row_in, input logic rdy);
      int         cidx;
      int         phase;
      logic [3:0] pr;
      bit         evt;
      bit         settled;
      logic [3:0] ek;
      logic       er;
      logic       was_valid;
      cidx  = (m_edges / SD) % 4;
      phase = m_edges % SD;
      pr    = ~m_rowq.pop_front();
      m_rowq.push_back(row_in);
      evt = 0; ek = 4'h0; er = 1'b0;
      if (phase == SD - 1) begin
         m_scan[cidx*4 +: 4] = pr;
         if (cidx == 3) begin
            m_hist.push_back(m_scan);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            settled = (m_hist.size() == DB);
            foreach (m_hist[i]) if (m_hist[i] != m_scan) settled = 0;
            if (settled && (m_scan != m_stable)) begin
               if (m_stable == 16'h0 && $countones(m_scan) == 1) begin
                  evt = 1; ek = bit_pos(m_scan); er = 1'b0;
               end
`ifdef KEYPAD_RELEASE_EN
               if ($countones(m_stable) == 1 && m_scan == 16'h0) begin
                  evt = 1; ek = bit_pos(m_stable); er = 1'b1;
               end
`endif
               m_stable = m_scan;
            end
         end
      end
      was_valid = m_valid;
      if (was_valid && rdy) begin
         m_valid = 1'b0;
         m_ovf   = 1'b0;
      end
      if (evt) begin
         if (!was_valid || rdy) begin
            m_valid = 1'b1; m_key = ek; m_rel = er;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_edges++;
   endtask

   // Reference update at each posedge, full output comparison at each negedge.
   initial begin
      logic [3:0] one;
      logic [3:0] exp_col;
      one = 4'b0001;
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else begin
            if (valid && ready) begin
               acc_cnt++;
               acc_key.push_back(key);
               acc_rel.push_back(rel);
            end
            model_step(row, ready);
         end
         @(negedge clk);
         if (!rst_n) model_reset();
         exp_col = ~(one << ((m_edges / SD) % 4));
         chk("col",   32'(col),   32'(exp_col));
         chk("valid", 32'(valid), 32'(m_valid));
         chk("key",   32'(key),   32'(m_key));
         chk("rel",   32'(rel),   32'(m_rel));
         chk("ovf",   32'(ovf),   32'(m_ovf));
         chk("any",   32'(any),   32'(|m_stable));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Stimulus with literal expectations.
   initial begin
      int base;
      int base2;
      int waited;
      cyc(3);
      rst_n = 1'b1;

      // 1: reset asserted mid-scan, asynchronously
      cyc(7);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_col",   32'(col),   32'h0000000E);
      chk("t1_rst_valid", 32'(valid), 32'h0);
      chk("t1_rst_ovf",   32'(ovf),   32'h0);
      chk("t1_rst_any",   32'(any),   32'h0);
      @(negedge clk);
      cyc(2);
      rst_n = 1'b1;
      chk("t1_col0", 32'(col), 32'h0000000E);
      cyc(4); chk("t1_col1", 32'(col), 32'h0000000D);
      cyc(4); chk("t1_col2", 32'(col), 32'h0000000B);
      cyc(4); chk("t1_col3", 32'(col), 32'h00000007);
      cyc(4); chk("t1_colw", 32'(col), 32'h0000000E);

      // 2: key 9 held clean, consumer not ready
      ready = 1'b0;
      keys  = 16'h0200;
      waited = 0;
      while (!valid && waited < 48) begin
         @(negedge clk);
         waited++;
      end
      chk("t2_valid", 32'(valid), 32'h1);
      chk("t2_key",   32'(key),   32'h9);
      chk("t2_rel",   32'(rel),   32'h0);
      chk("t2_any",   32'(any),   32'h1);
      cyc(20);
      chk("t2_hold",  32'(valid), 32'h1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("t2_drain", 32'(valid), 32'h0);
      keys  = 16'h0000;
      ready = 1'b1;
      cyc(64);

      // 3: key 9 bouncing for two scans, then held
      base = acc_cnt;
      for (int i = 0; i < 32; i++) begin
         if (i % 3 == 0) keys[9] = ~keys[9];
         @(negedge clk);
      end
      keys[9] = 1'b1;
      cyc(64);
      chk("t3_events", 32'(acc_cnt - base), 32'h1);
      chk("t3_key",    32'(acc_key[base]),  32'h9);
      keys = 16'h0000;
      cyc(64);

      // 4: chord 0+5, release 5 only, then full release and press 5
      base = acc_cnt;
      keys = 16'h0021;
      cyc(64);
      keys = 16'h0001;
      cyc(64);
      chk("t4_no_event", 32'(acc_cnt - base), 32'h0);
      keys = 16'h0000;
      cyc(64);
      base2 = acc_cnt;
      keys  = 16'h0020;
      cyc(64);
      chk("t4_events", 32'(acc_cnt - base2), 32'h1);
      chk("t4_key",    32'(acc_key[base2]),  32'h5);
      keys = 16'h0000;
      cyc(64);

      // 5: overflow while the slot is held
      ready = 1'b0;
      cyc(2);
      keys = 16'h0008; cyc(64);
      keys = 16'h0000; cyc(64);
      keys = 16'h1000; cyc(64);
      keys = 16'h0000; cyc(64);
      chk("t5_valid", 32'(valid), 32'h1);
      chk("t5_key",   32'(key),   32'h3);
      chk("t5_ovf",   32'(ovf),   32'h1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("t5_valid_clr", 32'(valid), 32'h0);
      chk("t5_ovf_clr",   32'(ovf),   32'h0);

      // 6: press and release key 15 with consumer ready
      ready = 1'b1;
      base  = acc_cnt;
      keys  = 16'h8000; cyc(64);
      keys  = 16'h0000; cyc(64);
`ifdef KEYPAD_RELEASE_EN
      chk("t6_events", 32'(acc_cnt - base), 32'h2);
      if (acc_key.size() > base + 1) begin
         chk("t6_key0", 32'(acc_key[base]),     32'hF);
         chk("t6_rel0", 32'(acc_rel[base]),     32'h0);
         chk("t6_key1", 32'(acc_key[base + 1]), 32'hF);
         chk("t6_rel1", 32'(acc_rel[base + 1]), 32'h1);
      end
`else
      chk("t6_events", 32'(acc_cnt - base), 32'h1);
      if (acc_key.size() > base) begin
         chk("t6_key0", 32'(acc_key[base]), 32'hF);
         chk("t6_rel0", 32'(acc_rel[base]), 32'h0);
      end
`endif

      // randomized phase: singles, chords, bounces and a flaky consumer
      for (int n = 0; n < 80; n++) begin
         int sel;
         int hold;
         sel = int'($urandom_range(0, 9));
         if (sel < 4)      keys = 16'h0000;
         else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
         else              keys = (16'h0001 << $urandom_range(0, 15)) |
                                  (16'h0001 << $urandom_range(0, 15));
         hold = int'($urandom_range(6, 90));
         for (int h = 0; h < hold; h++) begin
            ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
      end
      keys  = 16'h0000;
      ready = 1'b1;
      cyc(64);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
